// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM memory ops into req/ack transactions and registers results toward MEM/WB.
// Optional REQ-cycle timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int DW  = 32,
  parameter int WNW = 5
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     WB_in,
  input  logic [1:0]     MEM_in,
  input  logic [DW-1:0]  alu_in,
  input  logic [DW-1:0]  RD2_in,
  input  logic [WNW-1:0] WN_in,
  output logic           mem_req,
  output logic           mem_we,
  output logic [DW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           stall,
  output logic           misalign,
  output logic [1:0]     WB_out,
  output logic [DW-1:0]  rd_data_out,
  output logic [DW-1:0]  alu_out,
  output logic [WNW-1:0] WN_out,
`ifdef MEM_TIMEOUT_EN
  output logic           timeout,
`endif
  output logic           valid_out
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t         state_q;
  logic           mem_req_q, mem_we_q, misalign_q, valid_q;
  logic [DW-1:0]  mem_addr_q, mem_wdata_q, rd_data_q, alu_out_q;
  logic [1:0]     wb_out_q, wb_lat_q;
  logic [WNW-1:0] wn_out_q, wn_lat_q;

  logic is_mem, is_wr, is_mis, stall_d;

  assign is_mem = |MEM_in;
  assign is_wr  = MEM_in[1];  // 2'b11 resolves to a write
  assign is_mis = is_mem && (alu_in[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  logic          tmo_hit;
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign timeout = timeout_q;
`endif

  always_comb begin
    stall_d = 1'b0;
    case (state_q)
      IDLE: stall_d = is_mem && !is_mis;
`ifdef MEM_TIMEOUT_EN
      REQ:  stall_d = !mem_ack && !tmo_hit;
`else
      REQ:  stall_d = !mem_ack;
`endif
      default: stall_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      misalign_q  <= 1'b0;
      valid_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      alu_out_q   <= '0;
      wb_out_q    <= 2'b00;
      wb_lat_q    <= 2'b00;
      wn_out_q    <= '0;
      wn_lat_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (is_mem && !is_mis) begin
            state_q     <= REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_wr;
            mem_addr_q  <= {alu_in[DW-1:2], 2'b00};
            mem_wdata_q <= RD2_in;
            wb_lat_q    <= WB_in;
            wn_lat_q    <= WN_in;
            wb_out_q    <= 2'b00;
            valid_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end else begin
            // Misaligned ops flow through as a squashed (no write-back) instruction.
            wb_out_q   <= is_mis ? 2'b00 : WB_in;
            alu_out_q  <= alu_in;
            wn_out_q   <= WN_in;
            rd_data_q  <= '0;
            valid_q    <= 1'b1;
            misalign_q <= is_mis;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            wb_out_q  <= wb_lat_q;
            alu_out_q <= mem_addr_q;
            wn_out_q  <= wn_lat_q;
            rd_data_q <= mem_we_q ? '0 : mem_rdata;
            valid_q   <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            wb_out_q  <= 2'b00;
            alu_out_q <= mem_addr_q;
            wn_out_q  <= wn_lat_q;
            rd_data_q <= '0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
          else begin
            wb_out_q <= 2'b00;
            valid_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall       = stall_d;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign misalign    = misalign_q;
  assign WB_out      = wb_out_q;
  assign rd_data_out = rd_data_q;
  assign alu_out     = alu_out_q;
  assign WN_out      = wn_out_q;
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, load/store handshakes, misalign, reset mid-request.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_in, MEM_in;
  logic [31:0] alu_in, RD2_in, mem_rdata;
  logic [4:0]  WN_in;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, misalign, valid_out;
  logic [31:0] mem_addr, mem_wdata, rd_data_out, alu_out;
  logic [1:0]  WB_out;
  logic [4:0]  WN_out;
`ifdef MEM_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DW(32), .WNW(5)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .WB_in(WB_in), .MEM_in(MEM_in), .alu_in(alu_in),
    .RD2_in(RD2_in), .WN_in(WN_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .misalign(misalign), .WB_out(WB_out),
    .rd_data_out(rd_data_out), .alu_out(alu_out), .WN_out(WN_out),
`ifdef MEM_TIMEOUT_EN
    .timeout(timeout),
`endif
    .valid_out(valid_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [4:0] wn);
    MEM_in = mem; WB_in = wb; alu_in = alu; RD2_in = rd2; WN_in = wn;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req",   mem_req,   0);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_wb",    WB_out,    0);
    check_eq("rst_alu",   alu_out,   0);
    check_eq("rst_addr",  mem_addr,  0);
    check_eq("rst_mis",   misalign,  0);

    // Non-memory op
    step(); rst = 1'b1;
    drive(2'b00, 2'b10, 32'h1234, 32'h0, 5'd5);
    @(negedge clk);
    check_eq("alu_stall", stall, 0);
    step(); drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("alu_wb",    WB_out,    2'b10);
    check_eq("alu_alu",   alu_out,   32'h1234);
    check_eq("alu_wn",    WN_out,    5);
    check_eq("alu_valid", valid_out, 1);
    check_eq("alu_req",   mem_req,   0);
    $display("txn nop alu=0x1234 -> wb=%b alu=0x%0h wn=%0d", WB_out, alu_out, WN_out);

    // Load, ack on the 4th REQ cycle
    step(); drive(2'b01, 2'b01, 32'h40, 32'h0, 5'd7);
    @(negedge clk);
    check_eq("ld_stall_idle", stall,   1);
    check_eq("ld_req_idle",   mem_req, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      @(negedge clk);
      check_eq("ld_req_wait",   mem_req,   1);
      check_eq("ld_stall_wait", stall,     1);
      check_eq("ld_addr",       mem_addr,  32'h40);
      check_eq("ld_we",         mem_we,    0);
      check_eq("ld_bubble",     valid_out, 0);
    end
    step(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("ld_req_ack",   mem_req, 1);
    check_eq("ld_stall_ack", stall,   0);
    step(); mem_ack = 1'b0; mem_rdata = '0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("ld_rdata", rd_data_out, 32'hDEADBEEF);
    check_eq("ld_valid", valid_out,   1);
    check_eq("ld_wb",    WB_out,      2'b01);
    check_eq("ld_alu",   alu_out,     32'h40);
    check_eq("ld_wn",    WN_out,      7);
    check_eq("ld_req_done", mem_req,  0);
    $display("txn load addr=0x40 -> rdata=0x%0h", rd_data_out);

    // Store, immediate ack; rdata on the bus must not reach rd_data_out
    step(); drive(2'b10, 2'b00, 32'h80, 32'hCAFE0001, 5'd0);
    @(negedge clk);
    check_eq("st_stall_idle", stall, 1);
    step(); mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    check_eq("st_req",   mem_req,   1);
    check_eq("st_we",    mem_we,    1);
    check_eq("st_wdata", mem_wdata, 32'hCAFE0001);
    check_eq("st_addr",  mem_addr,  32'h80);
    check_eq("st_stall_ack", stall, 0);
    step(); mem_ack = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("st_rdata", rd_data_out, 0);
    check_eq("st_valid", valid_out,   1);
    check_eq("st_req_done", mem_req,  0);
    $display("txn store addr=0x80 data=0xcafe0001 -> rdata=0x%0h", rd_data_out);

    // MEM_in=11 behaves as a write
    step(); drive(2'b11, 2'b00, 32'h84, 32'h00000011, 5'd0);
    step(); mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    check_eq("rw_we", mem_we, 1);
    step(); mem_ack = 1'b0; drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("rw_rdata", rd_data_out, 0);
    $display("txn mem=11 addr=0x84 -> we=1 rdata=0x%0h", rd_data_out);

    // Misaligned load
    step(); drive(2'b01, 2'b01, 32'h42, 32'h0, 5'd3);
    @(negedge clk);
    check_eq("mis_stall", stall, 0);
    step(); drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("mis_flag",  misalign,  1);
    check_eq("mis_req",   mem_req,   0);
    check_eq("mis_wb",    WB_out,    2'b00);
    check_eq("mis_alu",   alu_out,   32'h42);
    check_eq("mis_valid", valid_out, 1);
    step();
    @(negedge clk);
    check_eq("mis_pulse", misalign, 0);
    $display("txn misaligned load addr=0x42 -> squashed");

    // Stray ack in IDLE
    step(); mem_ack = 1'b1; drive(2'b00, 2'b11, 32'h99, 32'h0, 5'd9);
    @(negedge clk);
    check_eq("idle_ack_stall", stall, 0);
    step(); mem_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack_req", mem_req, 0);
    check_eq("idle_ack_wb",  WB_out,  2'b11);

    // Reset during the 2nd REQ cycle, ack afterwards ignored
    step(); drive(2'b01, 2'b01, 32'h100, 32'h0, 5'd4);
    step();
    step(); rst = 1'b0;
    #1;
    check_eq("rr_req",   mem_req,   0);
    check_eq("rr_valid", valid_out, 0);
    check_eq("rr_addr",  mem_addr,  0);
    check_eq("rr_alu",   alu_out,   0);
    check_eq("rr_wn",    WN_out,    0);
    step(); mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step(); rst = 1'b1; drive(2'b00, 2'b10, 32'h77, 32'h0, 5'd2);
    @(negedge clk);
    check_eq("rr_stall", stall, 0);
    step(); mem_ack = 1'b0; mem_rdata = '0;
    drive(2'b01, 2'b01, 32'h200, 32'h0, 5'd6);
    @(negedge clk);
    check_eq("rr_post_valid", valid_out,   1);
    check_eq("rr_post_rdata", rd_data_out, 0);
    check_eq("rr_post_alu",   alu_out,     32'h77);
    check_eq("rr_post_req",   mem_req,     0);
    check_eq("rr_next_stall", stall,       1);
    step(); mem_ack = 1'b1; mem_rdata = 32'h0000BEEF;
    @(negedge clk);
    check_eq("rr_next_req", mem_req, 1);
    step(); mem_ack = 1'b0; drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("rr_next_rdata", rd_data_out, 32'h0000BEEF);
    check_eq("rr_next_wn",    WN_out,      6);
    $display("txn reset mid-request then load addr=0x200 -> rdata=0x%0h", rd_data_out);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack aborts after 4 REQ cycles
    step(); drive(2'b01, 2'b01, 32'h300, 32'h0, 5'd8);
    for (int i = 1; i <= 4; i++) begin
      step();
      @(negedge clk);
      check_eq("to_req", mem_req, 1);
      check_eq("to_stall", stall, (i == 4) ? 1'b0 : 1'b1);
    end
    step(); drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    check_eq("to_req_drop", mem_req,   0);
    check_eq("to_pulse",    timeout,   1);
    check_eq("to_wb",       WB_out,    2'b00);
    check_eq("to_valid",    valid_out, 1);
    step();
    @(negedge clk);
    check_eq("to_pulse_end", timeout, 0);
    $display("txn load addr=0x300 no ack -> timeout");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. Sits between that register and the MEM/WB register.
- Issues load/store requests to a data memory over a req/ack handshake. Registers results toward write-back.
- Drives a stall that deasserts en_reg on the upstream pipeline registers while a memory access is outstanding.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- DW, 32, data/address width
- WNW, 5, write-register-number width
- TIMEOUT, 16, max REQ cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- WB_in  in  2  write-back control from EX/MEM
- MEM_in  in  2  memory control from EX/MEM: [1]=MemWrite, [0]=MemRead
- alu_in  in  DW  ALU result / memory byte address
- RD2_in  in  DW  store data
- WN_in  in  WNW  destination register number
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  DW  word-aligned address
- mem_wdata  out  DW  store data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  DW  load data, valid with mem_ack
- stall  out  1  combinational; 1 = hold upstream registers
- misalign  out  1  1-cycle pulse: access squashed
- WB_out  out  2  to MEM/WB
- rd_data_out  out  DW  load data to MEM/WB
- alu_out  out  DW  ALU result to MEM/WB
- WN_out  out  WNW  to MEM/WB
- valid_out  out  1  output register holds a real instruction

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - mem_req, mem_we, misalign, valid_out = 0.
  - mem_addr, mem_wdata, rd_data_out, alu_out = 0.
  - WB_out=2'b00, WN_out=0.
  - Reset mid-request drops mem_req immediately. A mem_ack arriving after reset is ignored.
- A memory op is MEM_in != 2'b00. MEM_in=2'b11 is treated as a write only.
- A misaligned op is a memory op with alu_in[1:0] != 2'b00.
- FSM states: IDLE, REQ.
- IDLE, non-memory op:
  - stall=0.
  - Next edge: WB_out/alu_out/WN_out <= inputs, rd_data_out <= 0, valid_out <= 1.
- IDLE, misaligned op:
  - stall=0, no request issued.
  - Next edge: outputs loaded as for a non-memory op but WB_out <= 2'b00; misalign <= 1 for one cycle.
- IDLE, aligned memory op:
  - stall=1 combinationally.
  - Next edge: latch alu_in, RD2_in, WB_in, WN_in and write flag. mem_req <= 1, mem_we <= write flag. State -> REQ.
  - Output register loads a bubble: WB_out=0, valid_out=0.
- REQ:
  - mem_req, mem_addr, mem_wdata held stable until ack. stall = ~mem_ack.
  - Each edge with mem_ack=0: output register loads a bubble.
  - Edge with mem_ack=1:
    - mem_req <= 0, state -> IDLE.
    - Output register loads the latched WB/alu/WN and valid_out <= 1.
    - rd_data_out <= mem_rdata for reads, 0 for writes.
- Minimum memory-op latency: 2 cycles (IDLE + one REQ cycle with ack). Each extra ack-wait cycle adds 1.
- mem_ack while in IDLE: ignored.
- Back-to-back memory ops: the instruction following the completed access is sampled in the IDLE cycle right after the ack. There is no dead cycle beyond the mandatory IDLE cycle.
- misalign is never asserted in the same cycle as mem_req rising.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter counts REQ cycles without ack.
  - When the count reaches TIMEOUT, the next edge drops mem_req and returns to IDLE.
  - The output register is loaded with WB_out=0, valid_out=1, and the instruction is squashed.
  - A timeout output pulses for 1 cycle. stall=0 in that final cycle.
  - The counter clears on entry to REQ and on reset.
- Undefined: no counter and no timeout port; REQ waits indefinitely.

Test Plan:
- Non-memory op: MEM_in=00, WB_in=10, alu_in=0x1234, WN_in=5 -> next cycle WB_out=10, alu_out=0x1234, WN_out=5, valid_out=1, stall never 1.
- Load with ack delayed 3 cycles: MEM_in=01, alu_in=0x40; mem_rdata=0xDEADBEEF with ack -> mem_req high 4 cycles at mem_addr=0x40, stall high 4 cycles, then rd_data_out=0xDEADBEEF, valid_out=1.
- Store with immediate ack: MEM_in=10, alu_in=0x80, RD2_in=0xCAFE0001 -> mem_we=1, mem_wdata=0xCAFE0001 for 1 cycle, stall=1 for 1 cycle, total latency 2, rd_data_out=0.
- Misaligned load: MEM_in=01, alu_in=0x42 -> no mem_req, misalign=1 one cycle, WB_out=00, stall=0.
- Reset mid-REQ: drop rst during the 2nd REQ cycle, then assert ack -> mem_req=0 immediately, all outputs 0, ack ignored, next op handled normally.
- With MEM_TIMEOUT_EN and TIMEOUT=4: load with no ack -> after 4 REQ cycles mem_req=0, timeout pulse, WB_out=00, stall=0.
